// File: rtl/cpu_mem_access_pkg.sv
// cpu_mem_access_pkg: control-bit layout and state encodings for the mox125 memory-access stage
package cpu_mem_access_pkg;
  localparam int PCB_WIDTH = 8;
  localparam int PCB_WA = 0;
  localparam int PCB_WB = 1;
  localparam int PCB_RM = 2;
  localparam int PCB_WM = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cpu_mem_watchdog.sv
// cpu_mem_watchdog: counts cycles spent in a bus cycle and flags the last allowed one
module cpu_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  // counter restarts from zero each time a bus cycle begins
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= active_i ? cnt + CW'(1) : '0;
  assign timeout_o = active_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cpu_mem_access.sv
// cpu_mem_access: memory-access stage, one Wishbone-classic cycle per load/store (watchdog under CPU_MEM_TIMEOUT_EN)
module cpu_mem_access
  import cpu_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [31:0]          dmem_dat_i,
  input  logic                 dmem_ack_i,
  output logic                 dmem_cyc_o,
  output logic                 dmem_stb_o,
  output logic                 dmem_we_o,
  output logic [31:0]          dmem_adr_o,
  output logic [31:0]          dmem_dat_o,
  output logic [3:0]           dmem_sel_o,
  output logic                 stall_o,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic [31:0]          reg0_result_o,
  output logic [31:0]          reg1_result_o,
  output logic                 bus_error_o
);
  state_e state_q, state_d;
  logic bubble, mem_op, in_bus, ack, timeout;
  logic cyc_q, pend_wa, pend_wb, rd_q, bus_err_q;
  assign bubble  = pipeline_control_bits_i == '0;
  assign mem_op  = !bubble && (pipeline_control_bits_i[PCB_RM] || pipeline_control_bits_i[PCB_WM]);
  assign in_bus  = state_q == BUS;
  assign ack     = in_bus && dmem_ack_i;
  assign stall_o = in_bus && !dmem_ack_i;
  assign dmem_cyc_o = cyc_q;
  assign dmem_stb_o = cyc_q;
  assign bus_error_o = bus_err_q;
`ifdef CPU_MEM_TIMEOUT_EN
  cpu_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (in_bus),
    .timeout_o(timeout)
  );
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  // IDLE and DONE both capture upstream; BUS waits for ack (or the watchdog)
  always_comb begin
    state_d = state_q;
    state_d = in_bus ? (ack ? DONE : timeout ? IDLE : BUS) : (mem_op ? BUS : IDLE);
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // capture/forward datapath and bus master registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cyc_q <= 1'b0;
      dmem_we_o <= 1'b0;
      dmem_adr_o <= '0;
      dmem_dat_o <= '0;
      dmem_sel_o <= '0;
      register_wea_o <= 1'b0;
      register_web_o <= 1'b0;
      register0_write_index_o <= '0;
      register1_write_index_o <= '0;
      reg0_result_o <= '0;
      reg1_result_o <= '0;
      pend_wa <= 1'b0;
      pend_wb <= 1'b0;
      rd_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else if (!in_bus) begin
      register0_write_index_o <= register0_write_index_i;
      register1_write_index_o <= register1_write_index_i;
      reg0_result_o <= reg0_result_i;
      reg1_result_o <= reg1_result_i;
      register_wea_o <= !mem_op && pipeline_control_bits_i[PCB_WA];
      register_web_o <= !mem_op && pipeline_control_bits_i[PCB_WB];
      pend_wa <= pipeline_control_bits_i[PCB_WA];
      pend_wb <= pipeline_control_bits_i[PCB_WB];
      rd_q <= pipeline_control_bits_i[PCB_RM];
      bus_err_q <= 1'b0;
      if (mem_op) begin
        cyc_q <= 1'b1;
        dmem_we_o <= pipeline_control_bits_i[PCB_WM];
        dmem_adr_o <= memory_address_i;
        dmem_dat_o <= mem_result_i;
        dmem_sel_o <= 4'b1111;
      end
    end else begin
      register_wea_o <= ack && pend_wa;
      register_web_o <= ack && pend_wb;
      bus_err_q <= timeout && !ack;
      if (ack && rd_q) reg0_result_o <= dmem_dat_i;
      if (ack || timeout) cyc_q <= 1'b0;
    end
endmodule

// File: tb/tb_cpu_mem_access.sv
// tb_cpu_mem_access: directed self-checking bench for cpu_mem_access (timeout steps need CPU_MEM_TIMEOUT_EN)
module tb_cpu_mem_access;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pcb = '0;
  logic [3:0]  idx0 = '0, idx1 = '0;
  logic [31:0] adr = '0, mdat = '0, r0 = '0, r1 = '0, rdat = '0;
  logic        ack = 1'b0;
  logic        cyc, stb, we, stall, wea, web, berr;
  logic [31:0] adr_o, dat_o, r0_o, r1_o;
  logic [3:0]  sel, idx0_o, idx1_o;
  int n_cmp = 0;
  int n_err = 0;

  cpu_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipeline_control_bits_i(pcb),
    .register0_write_index_i(idx0), .register1_write_index_i(idx1),
    .memory_address_i(adr), .mem_result_i(mdat),
    .reg0_result_i(r0), .reg1_result_i(r1),
    .dmem_dat_i(rdat), .dmem_ack_i(ack),
    .dmem_cyc_o(cyc), .dmem_stb_o(stb), .dmem_we_o(we),
    .dmem_adr_o(adr_o), .dmem_dat_o(dat_o), .dmem_sel_o(sel),
    .stall_o(stall),
    .register_wea_o(wea), .register_web_o(web),
    .register0_write_index_o(idx0_o), .register1_write_index_o(idx1_o),
    .reg0_result_o(r0_o), .reg1_result_o(r1_o),
    .bus_error_o(berr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_r0", r0_o, 0);
    chk("rst_berr", 32'(berr), 0);
    tick();
    tick();
    rst = 1'b0;
    // bubble
    pcb = 8'h00; idx0 = 4'd5; r0 = 32'h77;
    tick();
    chk("bub_wea", 32'(wea), 0);
    chk("bub_web", 32'(web), 0);
    chk("bub_cyc", 32'(cyc), 0);
    // add r3 = 5
    pcb = 8'h01; idx0 = 4'd3; r0 = 32'h5;
    tick();
    chk("add_r0", r0_o, 32'h5);
    chk("add_idx", 32'(idx0_o), 3);
    chk("add_wea", 32'(wea), 1);
    chk("add_web", 32'(web), 0);
    chk("add_cyc", 32'(cyc), 0);
    // dual write
    pcb = 8'h03; idx1 = 4'd7; r1 = 32'h99;
    tick();
    chk("dual_web", 32'(web), 1);
    chk("dual_r1", r1_o, 32'h99);
    chk("dual_idx1", 32'(idx1_o), 7);
    // load with 3 wait cycles
    pcb = 8'h05; adr = 32'h1000; idx0 = 4'd2; r0 = 32'hAAAA;
    tick();
    pcb = 8'h01; idx0 = 4'd9; r0 = 32'h3333;
    chk("ld_cyc", 32'(cyc), 1);
    chk("ld_stb", 32'(stb), 1);
    chk("ld_we", 32'(we), 0);
    chk("ld_adr", adr_o, 32'h1000);
    chk("ld_sel", 32'(sel), 32'hF);
    chk("ld_wea_bus", 32'(wea), 0);
    chk("ld_stall1", 32'(stall), 1);
    tick();
    chk("ld_stall2", 32'(stall), 1);
    tick();
    chk("ld_stall3", 32'(stall), 1);
    tick();
    ack = 1'b1; rdat = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", 32'(stall), 0);
    chk("ld_cyc_ack", 32'(cyc), 1);
    tick();
    ack = 1'b0; rdat = 32'h0;
    chk("ld_r0", r0_o, 32'hDEADBEEF);
    chk("ld_wea", 32'(wea), 1);
    chk("ld_idx", 32'(idx0_o), 2);
    chk("ld_cyc_done", 32'(cyc), 0);
    tick();
    pcb = 8'h00;
    chk("nxt_r0", r0_o, 32'h3333);
    chk("nxt_idx", 32'(idx0_o), 9);
    chk("nxt_wea", 32'(wea), 1);
    tick();
    chk("nxt_wea_off", 32'(wea), 0);
    // push
    pcb = 8'h09; adr = 32'h0FFC; mdat = 32'h1234; r0 = 32'h0FFC; idx0 = 4'd15;
    tick();
    pcb = 8'h00; ack = 1'b1; rdat = 32'hBAD;
    chk("push_cyc", 32'(cyc), 1);
    chk("push_we", 32'(we), 1);
    chk("push_sel", 32'(sel), 32'hF);
    chk("push_dat", dat_o, 32'h1234);
    chk("push_adr", adr_o, 32'h0FFC);
    tick();
    ack = 1'b0;
    chk("push_wea", 32'(wea), 1);
    chk("push_r0", r0_o, 32'h0FFC);
    chk("push_idx", 32'(idx0_o), 15);
    chk("push_cyc_done", 32'(cyc), 0);
    tick();
    chk("push_wea_off", 32'(wea), 0);
    // back-to-back stores, ack held high
    pcb = 8'h08; adr = 32'h20; mdat = 32'h11; ack = 1'b1;
    tick();
    chk("st1_cyc", 32'(cyc), 1);
    chk("st1_dat", dat_o, 32'h11);
    chk("st1_stall", 32'(stall), 0);
    adr = 32'h24; mdat = 32'h22;
    tick();
    chk("st_gap_cyc", 32'(cyc), 0);
    chk("st1_wea", 32'(wea), 0);
    chk("st1_web", 32'(web), 0);
    tick();
    pcb = 8'h00;
    chk("st2_cyc", 32'(cyc), 1);
    chk("st2_adr", adr_o, 32'h24);
    chk("st2_dat", dat_o, 32'h22);
    tick();
    chk("st2_cyc_done", 32'(cyc), 0);
    chk("st2_wea", 32'(wea), 0);
    tick();
    chk("idle_ack_cyc", 32'(cyc), 0);
    ack = 1'b0;
    // reset during BUS
    pcb = 8'h05; adr = 32'h40;
    tick();
    chk("rb_cyc", 32'(cyc), 1);
    chk("rb_stall", 32'(stall), 1);
    #2 rst = 1'b1;
    #1;
    chk("rb_cyc_rst", 32'(cyc), 0);
    chk("rb_stb_rst", 32'(stb), 0);
    chk("rb_stall_rst", 32'(stall), 0);
    pcb = 8'h01; idx0 = 4'd4; r0 = 32'h42;
    tick();
    rst = 1'b0;
    tick();
    chk("rb_after_r0", r0_o, 32'h42);
    chk("rb_after_wea", 32'(wea), 1);
    chk("rb_after_cyc", 32'(cyc), 0);
    pcb = 8'h00;
    tick();
`ifdef CPU_MEM_TIMEOUT_EN
    pcb = 8'h05; adr = 32'h50;
    tick();
    pcb = 8'h00;
    chk("to_c1", 32'(cyc), 1);
    tick();
    chk("to_c2", 32'(cyc), 1);
    tick();
    chk("to_c3", 32'(cyc), 1);
    tick();
    chk("to_c4", 32'(cyc), 1);
    chk("to_berr_pre", 32'(berr), 0);
    tick();
    chk("to_cyc_drop", 32'(cyc), 0);
    chk("to_berr", 32'(berr), 1);
    chk("to_wea", 32'(wea), 0);
    chk("to_stall", 32'(stall), 0);
    tick();
    chk("to_berr_off", 32'(berr), 0);
    chk("to_wea2", 32'(wea), 0);
`else
    chk("berr_tied", 32'(berr), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_access.md
Name: cpu_mem_access

Overview:
Memory-access stage of the mox125 pipeline, directly downstream of execute and upstream of writeback. It captures execute results every cycle. When the control bits request a load or store, it runs one Wishbone-classic data-bus cycle using the execute-supplied address and store data, and holds the pipeline until the cycle completes. It forwards register results and write enables to writeback, and substitutes load data where required.

Parameters:
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (used only with the optional feature).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
pipeline_control_bits_i  in  PCB_WIDTH  control bits from execute
register0_write_index_i  in  4  port-A destination register
register1_write_index_i  in  4  port-B destination register
memory_address_i  in  32  byte address from execute
mem_result_i  in  32  store data from execute
reg0_result_i  in  32  port-A ALU result
reg1_result_i  in  32  port-B ALU result
dmem_dat_i  in  32  bus read data
dmem_ack_i  in  1  bus acknowledge
dmem_cyc_o  out  1  bus cycle
dmem_stb_o  out  1  bus strobe
dmem_we_o  out  1  bus write enable
dmem_adr_o  out  32  bus address
dmem_dat_o  out  32  bus write data
dmem_sel_o  out  4  byte lanes
stall_o  out  1  freeze fetch/decode/execute
register_wea_o  out  1  writeback port-A enable
register_web_o  out  1  writeback port-B enable
register0_write_index_o  out  4  port-A index
register1_write_index_o  out  4  port-B index
reg0_result_o  out  32  port-A value
reg1_result_o  out  32  port-B value
bus_error_o  out  1  one-cycle watchdog pulse (optional feature only)

Behaviour:
- Control bits used are PCB_WA, PCB_WB, PCB_RM (memory read) and PCB_WM (memory write). All other bits are ignored.
- An all-zero control word is a bubble. A bubble produces no bus cycle and no write enables.
- Reset: all outputs are 0. State is IDLE.
- States:
  - IDLE: no bus cycle in progress.
  - BUS: cyc/stb held until ack.
  - DONE: one-cycle writeback presentation of a memory op.
- IDLE, capture on every clock edge:
  - If neither RM nor WM is set: register indices, results and write enables (WA, WB) pass to the outputs with 1-cycle latency. State stays IDLE.
  - If RM or WM is set: latch adr = memory_address_i, dat_o = mem_result_i, we = WM, sel = 4'b1111. Assert cyc/stb on the next cycle. Go to BUS. Write enables are held at 0.
- BUS:
  - stall_o = !dmem_ack_i, combinational.
  - Upstream inputs are ignored; upstream holds them.
  - On ack: drop cyc/stb the same edge and go to DONE.
  - For a read, reg0_result_o = dmem_dat_i, latched on ack. Loads and pop return data on port A.
  - reg1_result_o = captured reg1_result_i, for the pop pointer update.
  - WA and WB are asserted for exactly one cycle in DONE.
- DONE: return to IDLE and capture the next input on that same edge. A memory op followed by another memory op reissues with one idle bus cycle between them.
- Ack in the first BUS cycle gives total memory-op latency of 2 cycles from capture to writeback.
- dmem_ack_i seen while in IDLE is ignored.
- Address alignment is not checked. The address is driven unmodified.
- Reset asserted during BUS drops cyc/stb immediately, asynchronously. The in-flight operation is discarded.
- Store-only ops (WM set, WA and WB clear) produce no write enables in DONE.
- Mixed ops (WM with WA, e.g. push or jsr): the store runs first, then reg0_result_o is the captured ALU result (the pointer) and WA fires in DONE.

Optional Feature:
Macro CPU_MEM_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter runs while in BUS. On reaching TIMEOUT_CYCLES without ack:
  - cyc/stb drop;
  - bus_error_o pulses for 1 cycle;
  - write enables are suppressed;
  - state returns to IDLE.
  The counter clears on entry to BUS.
- Undefined: no counter. BUS waits indefinitely. bus_error_o is tied to 0.

Decomposition:
- The shared defines header holds PCB_WIDTH, the PCB_WA/WB/RM/WM bit positions and the state encodings IDLE/BUS/DONE.
- One natural sub-module: cpu_mem_watchdog, which holds the timeout counter and is instantiated only under CPU_MEM_TIMEOUT_EN.

Test Plan:
- Bubble in, then an add result 0x5 to r3 with WA set → reg0_result_o=0x5, index 3, wea=1 one cycle later. No cyc asserted.
- Load: RM+WA, adr 0x1000, ack after 3 wait cycles with dat 0xDEADBEEF:
  - stall_o high for 3 cycles;
  - reg0_result_o=0xDEADBEEF and wea=1 for one cycle.
- Push: WM+WA, adr 0x0FFC, data 0x1234, reg0 0x0FFC → bus write we=1 sel=1111 dat=0x1234, then wea=1 with value 0x0FFC.
- Back-to-back stores, ack immediate → two bus cycles with exactly one idle cycle between them. No writeback enables.
- rst_i asserted mid-BUS → cyc/stb/stall low immediately. After release, the next input is processed normally.
- With CPU_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → cyc drops after 4 cycles, bus_error_o pulses once, wea stays 0.
